// File: rtl/cpu_pkg.sv
// Shared types and defaults for the MIPS pipeline front end.
// Holds the fetch FSM encoding and the reset PC / NOP encodings.
package cpu_pkg;

  typedef logic [31:0] word_t;

  localparam word_t RESET_PC_DEF  = 32'h0000_3000;
  localparam word_t NOP_INSTR_DEF = 32'h0000_0000;

  typedef enum logic {
    FETCH    = 1'b0,
    BUFFERED = 1'b1
  } fetch_state_e;

  function automatic logic misaligned(input word_t addr);
    return addr[1:0] != 2'b00;
  endfunction

endpackage

// File: rtl/if_id_reg.sv
// IF/ID pipeline register: PC, instruction word and fetch address-error flag.
// Loads when en is high; clr replaces the instruction with a NOP and drops the flag.
module if_id_reg
  import cpu_pkg::*;
#(
  parameter word_t NOP_INSTR = NOP_INSTR_DEF
) (
  input  logic  clk,
  input  logic  reset,
  input  logic  en,
  input  logic  clr,
  input  word_t pc_in,
  input  word_t instr_in,
  input  logic  exc_in,
  output word_t pc_out,
  output word_t instr_out,
  output logic  exc_out
);

  word_t pc_q, pc_d;
  word_t instr_q, instr_d;
  logic  exc_q, exc_d;

  always_comb begin
    pc_d    = pc_q;
    instr_d = instr_q;
    exc_d   = exc_q;
    if (en) begin
      pc_d    = pc_in;
      instr_d = clr ? NOP_INSTR : instr_in;
      exc_d   = clr ? 1'b0 : exc_in;
    end
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pc_q    <= '0;
      instr_q <= NOP_INSTR;
      exc_q   <= 1'b0;
    end else begin
      pc_q    <= pc_d;
      instr_q <= instr_d;
      exc_q   <= exc_d;
    end
  end

  assign pc_out    = pc_q;
  assign instr_out = instr_q;
  assign exc_out   = exc_q;

endmodule

// File: rtl/fetch_stage.sv
// IF stage: PC_F register, one-outstanding-request fetch FSM and one-entry skid buffer.
// Optional FETCH_ALIGN_CHECK_EN: misaligned PC_F skips memory and flags excAdEL_D.
module fetch_stage
  import cpu_pkg::*;
#(
  parameter word_t RESET_PC  = RESET_PC_DEF,
  parameter word_t NOP_INSTR = NOP_INSTR_DEF
) (
  input  logic  clk,
  input  logic  reset,
  input  logic  stall,
  input  logic  clearD,
  input  word_t nextPC,
  output logic  imReq,
  output word_t imAddr,
  input  logic  imRdy,
  input  word_t imData,
  output word_t PC_F,
  output word_t PC_D,
  output word_t instr_D,
  output logic  waitF,
  output logic  excAdEL_D
);

  fetch_state_e state_q, state_d;
  word_t        pc_f_q, pc_f_d;
  word_t        buf_q, buf_d;
  logic         im_req_q, im_req_d;

  logic  in_fetch;
  logic  mis_now, mis_next;
  logic  have_instr;
  logic  advance;
  word_t instr_sel;
  logic  exc_sel;

  assign in_fetch = (state_q == FETCH);

`ifdef FETCH_ALIGN_CHECK_EN
  assign mis_now  = misaligned(pc_f_q);
  assign mis_next = misaligned(pc_f_d);
`else
  assign mis_now  = 1'b0;
  assign mis_next = 1'b0;
`endif

  // A misaligned fetch never reaches memory, so the "instruction" is ready at once.
  assign have_instr = in_fetch ? (mis_now | imRdy) : 1'b1;
  assign advance    = have_instr & ~stall;
  assign exc_sel    = in_fetch & mis_now;

  always_comb begin
    if (!in_fetch)    instr_sel = buf_q;
    else if (mis_now) instr_sel = NOP_INSTR;
    else              instr_sel = imData;
  end

  always_comb begin
    state_d = state_q;
    pc_f_d  = pc_f_q;
    buf_d   = buf_q;
    if (advance) pc_f_d = nextPC;
    unique case (state_q)
      FETCH: begin
        if (!mis_now && imRdy && stall) begin
          buf_d   = imData;
          state_d = BUFFERED;
        end
      end
      BUFFERED: begin
        if (!stall) state_d = FETCH;
      end
      default: state_d = FETCH;
    endcase
    im_req_d = (state_d == FETCH) & ~mis_next;
  end

  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      state_q  <= FETCH;
      pc_f_q   <= RESET_PC;
      buf_q    <= NOP_INSTR;
      im_req_q <= ~misaligned(RESET_PC);
    end else begin
      state_q  <= state_d;
      pc_f_q   <= pc_f_d;
      buf_q    <= buf_d;
      im_req_q <= im_req_d;
    end
  end

  if_id_reg #(
    .NOP_INSTR(NOP_INSTR)
  ) u_if_id (
    .clk      (clk),
    .reset    (reset),
    .en       (advance),
    .clr      (clearD),
    .pc_in    (pc_f_q),
    .instr_in (instr_sel),
    .exc_in   (exc_sel),
    .pc_out   (PC_D),
    .instr_out(instr_D),
    .exc_out  (excAdEL_D)
  );

  assign imReq  = im_req_q;
  assign imAddr = pc_f_q;
  assign PC_F   = pc_f_q;
  assign waitF  = ~have_instr;

endmodule

// File: tb/tb_fetch_stage.sv
// Self-checking bench for fetch_stage: directed vector table, hand-written corner
// sequences and a randomized run against a transaction-level fetch model.
module tb_fetch_stage;

  logic        clk = 1'b0;
  logic        reset = 1'b1;
  logic        stall = 1'b0;
  logic        clearD = 1'b0;
  logic [31:0] nextPC = '0;
  logic        imReq;
  logic [31:0] imAddr;
  logic        imRdy = 1'b0;
  logic [31:0] imData = '0;
  logic [31:0] PC_F, PC_D, instr_D;
  logic        waitF;
  logic        excAdEL_D;

  int checks = 0;
  int failures = 0;

  fetch_stage dut (
    .clk      (clk),
    .reset    (reset),
    .stall    (stall),
    .clearD   (clearD),
    .nextPC   (nextPC),
    .imReq    (imReq),
    .imAddr   (imAddr),
    .imRdy    (imRdy),
    .imData   (imData),
    .PC_F     (PC_F),
    .PC_D     (PC_D),
    .instr_D  (instr_D),
    .waitF    (waitF),
    .excAdEL_D(excAdEL_D)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic        stall;
    logic        clr;
    logic        rdy;
    logic [31:0] data;
    logic [31:0] npc;
    logic        e_req;
    logic        e_wait;
    logic [31:0] e_pcf;
    logic [31:0] e_pcd;
    logic [31:0] e_ins;
  } vec_t;

  vec_t tv[11];

  task automatic chk32(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%h expected=%h t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic chk1(input string name, input logic act, input logic exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s actual=%b expected=%b t=%0t", name, act, exp, $time);
    end
  endtask

  task automatic drive(input logic s, input logic c, input logic r,
                       input logic [31:0] d, input logic [31:0] n);
    stall  = s;
    clearD = c;
    imRdy  = r;
    imData = d;
    nextPC = n;
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h0);
    @(posedge clk);
    #2;
    reset = 1'b0;
    #1;
  endtask

  function automatic logic [31:0] memf(input logic [31:0] a);
    return {a[15:0], ~a[15:0]} ^ 32'h1357_9BDF;
  endfunction

  // Randomized-run model state: what the IF/ID register should hold, and where fetch is.
  logic [31:0] m_pc, e_pcd, e_ins, npc, d;
  logic        m_got, req, rdy, s, c, avail;
  int          lat;

  initial begin
    tv[0]  = '{1'b0, 1'b0, 1'b1, 32'h2001_0001, 32'h3004, 1'b1, 1'b0, 32'h3000, 32'h0,    32'h0};
    tv[1]  = '{1'b0, 1'b0, 1'b1, 32'h2002_0002, 32'h3008, 1'b1, 1'b0, 32'h3004, 32'h3000, 32'h2001_0001};
    tv[2]  = '{1'b0, 1'b0, 1'b0, 32'hDEAD_BEEF, 32'h300C, 1'b1, 1'b1, 32'h3008, 32'h3004, 32'h2002_0002};
    tv[3]  = '{1'b1, 1'b0, 1'b0, 32'hDEAD_BEEF, 32'h300C, 1'b1, 1'b1, 32'h3008, 32'h3004, 32'h2002_0002};
    tv[4]  = '{1'b1, 1'b0, 1'b1, 32'h2402_0005, 32'h300C, 1'b1, 1'b0, 32'h3008, 32'h3004, 32'h2002_0002};
    tv[5]  = '{1'b1, 1'b0, 1'b1, 32'h1111_1111, 32'h300C, 1'b0, 1'b0, 32'h3008, 32'h3004, 32'h2002_0002};
    tv[6]  = '{1'b0, 1'b0, 1'b0, 32'h0,         32'h3040, 1'b0, 1'b0, 32'h3008, 32'h3004, 32'h2002_0002};
    tv[7]  = '{1'b0, 1'b1, 1'b1, 32'h8C01_0000, 32'h3044, 1'b1, 1'b0, 32'h3040, 32'h3008, 32'h2402_0005};
    tv[8]  = '{1'b1, 1'b1, 1'b1, 32'h3333_3333, 32'h3048, 1'b1, 1'b0, 32'h3044, 32'h3040, 32'h0};
    tv[9]  = '{1'b0, 1'b0, 1'b0, 32'h0,         32'h3048, 1'b0, 1'b0, 32'h3044, 32'h3040, 32'h0};
    tv[10] = '{1'b0, 1'b0, 1'b0, 32'h0,         32'h304C, 1'b1, 1'b1, 32'h3048, 32'h3044, 32'h3333_3333};

    // Reset values and directed table.
    do_reset();
    chk32("rst_pc_f", PC_F, 32'h3000);
    chk32("rst_pc_d", PC_D, 32'h0);
    chk32("rst_instr_d", instr_D, 32'h0);
    chk1("rst_imreq", imReq, 1'b1);
    chk1("rst_exc", excAdEL_D, 1'b0);
    for (int i = 0; i < 11; i++) begin
      drive(tv[i].stall, tv[i].clr, tv[i].rdy, tv[i].data, tv[i].npc);
      #1;
      chk1($sformatf("tv%0d_imreq", i), imReq, tv[i].e_req);
      chk1($sformatf("tv%0d_waitf", i), waitF, tv[i].e_wait);
      chk32($sformatf("tv%0d_pc_f", i), PC_F, tv[i].e_pcf);
      chk32($sformatf("tv%0d_imaddr", i), imAddr, tv[i].e_pcf);
      chk32($sformatf("tv%0d_pc_d", i), PC_D, tv[i].e_pcd);
      chk32($sformatf("tv%0d_instr_d", i), instr_D, tv[i].e_ins);
      tick();
    end

    // Three-cycle memory delay at 0x3004.
    do_reset();
    drive(1'b0, 1'b0, 1'b1, 32'hAAAA_0001, 32'h3004);
    tick();
    for (int k = 0; k < 3; k++) begin
      drive(1'b0, 1'b0, 1'b0, 32'hFFFF_FFFF, 32'h3010);
      #1;
      chk1("dly_waitf", waitF, 1'b1);
      chk32("dly_pc_f", PC_F, 32'h3004);
      tick();
      chk32("dly_pc_d", PC_D, 32'h3000);
      chk32("dly_instr_d", instr_D, 32'hAAAA_0001);
    end
    drive(1'b0, 1'b0, 1'b1, 32'hBBBB_0002, 32'h3010);
    #1;
    chk1("dly_hit_waitf", waitF, 1'b0);
    tick();
    chk32("dly_hit_instr_d", instr_D, 32'hBBBB_0002);
    chk32("dly_hit_pc_d", PC_D, 32'h3004);
    chk32("dly_hit_pc_f", PC_F, 32'h3010);

    // Branch in D waits for its delay slot, which misses twice.
    do_reset();
    drive(1'b0, 1'b0, 1'b1, 32'h2001_0001, 32'h3004);
    tick();
    drive(1'b0, 1'b0, 1'b1, 32'h1000_000E, 32'h3008);
    tick();
    for (int k = 0; k < 2; k++) begin
      drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h3040);
      #1;
      chk32("beq_imaddr_ds", imAddr, 32'h3008);
      tick();
      chk32("beq_pc_d_hold", PC_D, 32'h3004);
    end
    drive(1'b0, 1'b0, 1'b1, 32'h0000_0021, 32'h3040);
    tick();
    chk32("beq_ds_pc_d", PC_D, 32'h3008);
    chk32("beq_target", imAddr, 32'h3040);
    chk1("beq_target_req", imReq, 1'b1);

    // Reset asserted while BUFFERED.
    do_reset();
    drive(1'b1, 1'b0, 1'b1, 32'h2402_0005, 32'h3004);
    tick();
    chk1("buf_imreq", imReq, 1'b0);
    #2;
    reset = 1'b1;
    #1;
    chk32("midrst_pc_f", PC_F, 32'h3000);
    chk32("midrst_instr_d", instr_D, 32'h0);
    chk1("midrst_imreq", imReq, 1'b1);
    #1;
    reset = 1'b0;
    drive(1'b0, 1'b0, 1'b1, 32'h0000_0042, 32'h3004);
    tick();
    chk32("postrst_instr_d", instr_D, 32'h0000_0042);
    chk32("postrst_pc_d", PC_D, 32'h3000);

`ifdef FETCH_ALIGN_CHECK_EN
    do_reset();
    drive(1'b0, 1'b0, 1'b1, 32'h1234_5678, 32'h3002);
    tick();
    drive(1'b0, 1'b0, 1'b0, 32'h0, 32'h3008);
    #1;
    chk1("aln_imreq", imReq, 1'b0);
    chk1("aln_waitf", waitF, 1'b0);
    tick();
    chk1("aln_exc", excAdEL_D, 1'b1);
    chk32("aln_instr_d", instr_D, 32'h0);
    chk32("aln_pc_d", PC_D, 32'h3002);
    chk1("aln_next_req", imReq, 1'b1);
`endif

    // Randomized run against the transaction-level model.
    do_reset();
    m_pc  = 32'h3000;
    m_got = 1'b0;
    e_pcd = 32'h0;
    e_ins = 32'h0;
    lat   = int'($urandom_range(0, 3));
    for (int n = 0; n < 400; n++) begin
      s   = ($urandom % 4) == 0;
      c   = ($urandom % 5) == 0;
      req = !m_got;
      if (req) begin
        rdy = (lat == 0);
        if (lat != 0) lat--;
        d = rdy ? memf(m_pc) : $urandom;
      end else begin
        rdy = 1'($urandom % 2);
        d   = $urandom;
      end
      npc = (($urandom % 6) == 0) ? (32'h3000 + (32'($urandom_range(0, 1023)) << 2)) : m_pc + 32'd4;
      drive(s, c, rdy, d, npc);
      #1;
      avail = m_got || (req && rdy);
      chk1("rnd_imreq", imReq, req);
      chk32("rnd_imaddr", imAddr, m_pc);
      chk1("rnd_waitf", waitF, !avail);
      if (avail && !s) begin
        e_pcd = m_pc;
        e_ins = c ? 32'h0 : memf(m_pc);
        m_pc  = npc;
        m_got = 1'b0;
        lat   = int'($urandom_range(0, 3));
      end else if (req && rdy) begin
        m_got = 1'b1;
      end
      tick();
      chk32("rnd_pc_d", PC_D, e_pcd);
      chk32("rnd_instr_d", instr_D, e_ins);
      chk32("rnd_pc_f", PC_F, m_pc);
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/fetch_stage.md
Name: fetch_stage

Overview:
- IF stage of the 5-stage MIPS pipeline, directly upstream of the decode stage.
- Owns the PC_F register and issues one-outstanding-request fetches to a variable-latency instruction memory.
- Holds a one-entry skid buffer for an instruction that returns while decode is stalled, and owns the IF/ID pipeline register (PC_D, instr_D) consumed by decode.
- Takes nextPC from the decode-stage NPC each cycle; the branch delay slot is preserved by construction.

Parameters:
- RESET_PC, 32'h0000_3000, PC_F value after reset.
- NOP_INSTR, 32'h0000_0000, encoding injected into IF/ID on reset or clear.

Ports:
- clk  input  1  single clock, rising edge
- reset  input  1  asynchronous, active-high
- stall  input  1  decode stall from hazard unit; freezes PC_F and IF/ID
- clearD  input  1  load NOP_INSTR into IF/ID instead of fetched word when advancing
- nextPC  input  32  next fetch address from decode-stage NPC
- imReq  output  1  instruction memory request valid
- imAddr  output  32  request address (= PC_F)
- imRdy  input  1  memory response valid for the outstanding request
- imData  input  32  response word
- PC_F  output  32  current fetch PC (to NPC)
- PC_D  output  32  IF/ID PC
- instr_D  output  32  IF/ID instruction
- waitF  output  1  no instruction available this cycle; hazard unit bubbles EX
- excAdEL_D  output  1  IF/ID fetch-address-error flag (see Optional Feature)

Behaviour:
- Reset (async, any state):
  - PC_F=RESET_PC, PC_D=0, instr_D=NOP_INSTR, excAdEL_D=0, state=FETCH, buffer cleared.
  - imReq is 1 in the first cycle after reset deassert.
  - Memory shares reset and drops any in-flight request.
- States: FETCH, BUFFERED.
- FETCH:
  - imReq=1, imAddr=PC_F.
  - haveInstr = imRdy.
  - If imRdy && !stall: IF/ID <= {PC_F, imData}, or {PC_F, NOP_INSTR} if clearD. PC_F <= nextPC. Stay in FETCH; a new request goes out next cycle.
  - If imRdy && stall: buf <= imData, go to BUFFERED. PC_F and IF/ID hold.
  - If !imRdy: PC_F and IF/ID hold, regardless of stall.
- BUFFERED:
  - imReq=0. haveInstr=1.
  - If !stall: IF/ID <= {PC_F, buf}, or NOP if clearD. PC_F <= nextPC. Go to FETCH.
  - If stall: hold.
- waitF = !haveInstr, combinational from state and imRdy only; it must never depend on stall.
- IF/ID never loads a bubble on a miss. A branch in D stays in D until its delay slot has been fetched, so nextPC is consumed exactly once, at the advance edge.
- clearD with no advance: no effect. clearD together with stall: stall wins, hold.
- imRdy while imReq=0: ignored.
- Latency: with zero-wait memory (imRdy same cycle), one instruction per cycle and fetch-to-D is 1 cycle.
- No arithmetic in this block; PC+4 is produced by NPC.

Optional Feature:
- Macro: FETCH_ALIGN_CHECK_EN.
- Defined:
  - If PC_F[1:0]!=0 in FETCH, imReq=0 and haveInstr=1 without waiting on memory.
  - On advance, IF/ID <= {PC_F, NOP_INSTR} with excAdEL_D=1. Otherwise excAdEL_D is loaded as 0 on every advance.
  - excAdEL_D holds with IF/ID on stall.
- Undefined:
  - PC_F[1:0] is passed to imAddr unchanged and memory ignores it.
  - excAdEL_D is tied 0.

Decomposition:
- Shared package cpu_pkg:
  - RESET_PC and NOP_INSTR defaults.
  - Fetch-state enum (FETCH, BUFFERED).
  - 32-bit word typedef.
- One natural sub-module, if_id_reg: holds PC_D, instr_D and excAdEL_D, with enable, clear and async reset.
- The FSM, PC_F register and skid buffer stay in fetch_stage.

Test Plan:
- Reset release, imRdy tied 1, stall=0, nextPC=PC_F+4 -> imAddr 0x3000, 0x3004, 0x3008 on consecutive cycles; PC_D trails PC_F by 1 cycle; waitF=0 throughout.
- imRdy delayed 3 cycles at PC_F=0x3004 -> waitF=1 for 3 cycles; PC_F, PC_D and instr_D hold; on the 4th cycle instr_D=imData and PC_F=nextPC.
- Response 0x2402_0005 arrives while stall=1 -> state BUFFERED and imReq=0; stall drops 2 cycles later -> instr_D=0x2402_0005, PC_F=nextPC, imReq=1 next cycle.
- beq in D with nextPC=0x3040 while the delay-slot fetch at 0x3008 misses for 2 cycles -> PC_D stays on the beq; after the delay slot lands in D, imAddr=0x3040.
- clearD=1 on an advance with imData=0x8C01_0000 -> instr_D=0, PC_D=fetched PC. reset asserted mid-BUFFERED -> immediate PC_F=0x3000, instr_D=0, state=FETCH.
- With FETCH_ALIGN_CHECK_EN and nextPC=0x3002 -> imReq=0; next advance gives excAdEL_D=1, instr_D=0, PC_D=0x3002.
